rf_writeback_arbiter: RTL and testbench
=======================================

Name: rf_writeback_arbiter

Overview:
- Writer-side front end of the integer register file: merges writeback requests from the ALU path and the load (MEM) path into the single register-file write port.
- Each source has a one-entry skid buffer and a valid/ready handshake; a fixed-priority arbiter with anti-starvation drives rf_write_en/rf_write_id/rf_write_data.
- Exports a pending-register mask for hazard detection in decode.

Parameters:
- XLEN, 32, data width.
- REG_ID_W, 5, register id width.
- NUM_REGS, 32, register count; pending_mask width.
- STARVE_MAX, 3, consecutive cycles a buffered ALU entry may lose before it is forced to win; legal range 1..15.

Ports:
- clk  input  1  clock, rising edge.
- reset_n  input  1  synchronous, active-low reset.
- alu_valid  input  1  ALU writeback request valid.
- alu_ready  output  1  ALU request accepted when alu_valid && alu_ready at a rising edge.
- alu_rd  input  REG_ID_W  ALU destination register.
- alu_data  input  XLEN  ALU result.
- mem_valid  input  1  load writeback request valid.
- mem_ready  output  1  load handshake ready.
- mem_rd  input  REG_ID_W  load destination register.
- mem_data  input  XLEN  load result.
- rf_write_en  output  1  register-file write enable.
- rf_write_id  output  REG_ID_W  register-file write index.
- rf_write_data  output  XLEN  register-file write data.
- pending_mask  output  NUM_REGS  bit r set while any buffered entry targets r.
- fwd_id  input  REG_ID_W  forwarding lookup id (see Optional Feature).
- fwd_hit  output  1  forwarding hit.
- fwd_data  output  XLEN  forwarding data.

Behaviour:
- Reset (clk edge with reset_n=0):
  - Both buffers empty and the starvation counter is 0.
  - rf_write_en=0, rf_write_id=0, rf_write_data=0, pending_mask=0, fwd_hit=0, fwd_data=0.
  - alu_ready=mem_ready=0 while reset_n=0.
  - Entries in flight are discarded; no write is issued for them.
- Buffers:
  - Each source has a one-entry register {valid, rd, data}.
  - src_ready = !buf_valid || buf drained this cycle. Ready is combinational from buffer state and grant, and never depends on src_valid.
  - An accepted request with rd==0 is consumed, not buffered, and never produces a write. x0 stays zero.
- Write port:
  - Purely combinational from the granted buffer: rf_write_en = grant valid; id and data come from that buffer.
  - When rf_write_en=0, id and data are driven 0.
  - Latency: handshake at edge k, then rf_write_en high during cycle k..k+1, and the register file captures at edge k+1 (one cycle minimum).
- Arbitration, one write per cycle:
  - Only one buffer valid: that buffer is granted.
  - Both valid: MEM is granted, unless starve_cnt==STARVE_MAX, in which case ALU is granted.
  - starve_cnt increments each cycle the ALU buffer is valid and loses. It clears when ALU is granted or its buffer is empty, and saturates at STARVE_MAX.
  - The granted buffer empties at the edge. It may reload at the same edge if its source handshakes; this gives back-to-back throughput of one per cycle per source.
- Same rd in both buffers: no reordering is performed. Upstream guarantees in-order completion per rd. The pending bit stays set until both entries drain.
- pending_mask is combinational: the OR of one-hot(rd) over valid buffers. It is never set for rd==0.
- rd >= NUM_REGS: treated like rd==0 (discarded).

Optional Feature:
- Macro RF_WB_FWD_EN.
- Defined:
  - fwd_hit=1 when fwd_id!=0 and a valid buffer holds rd==fwd_id.
  - fwd_data is that buffer's data.
  - If both buffers match, the MEM buffer's data is returned.
  - Combinational, same cycle.
- Undefined: fwd_hit and fwd_data are tied to 0, and no comparators are built.

Decomposition:
- Package rf_wb_pkg:
  - typedef wb_req_t {logic [REG_ID_W-1:0] rd; logic [XLEN-1:0] data;}.
  - enum wb_src_e {WB_SRC_NONE, WB_SRC_ALU, WB_SRC_MEM}.
  - Default XLEN, REG_ID_W, NUM_REGS constants.
- Sub-module wb_skid_buffer: one-entry valid/ready buffer with drain input and x0 drop. Instantiated twice.
- The top holds the arbiter, starvation counter, pending mask and forwarding mux.

Test Plan:
- Reset mid-operation: both buffers full, then reset_n=0 for one edge -> rf_write_en=0, pending_mask=0, ready=0 during reset; after release no stale write appears.
- ALU only: alu rd=5, data=0xDEADBEEF at edge k -> rf_write_en=1, id=5, data=0xDEADBEEF in cycle k, and pending_mask[5]=1 for that cycle only.
- Contention with STARVE_MAX=3: MEM streams continuously while ALU holds rd=7 -> MEM wins 3 cycles, ALU is written on the 4th, then MEM resumes.
- x0 drop: mem rd=0, data=0x1234 with mem_ready=1 -> handshake completes, rf_write_en stays 0, pending_mask stays 0.
- Throughput: both sources valid every cycle for 20 cycles -> exactly one write per cycle, no lost or duplicated entries, and the scoreboard matches the expected order.
- With RF_WB_FWD_EN defined: ALU buffer rd=9, data=0x55 and MEM buffer rd=9, data=0x66, fwd_id=9 -> fwd_hit=1, fwd_data=0x66. With fwd_id=0 -> fwd_hit=0.

Source files
------------

// File: rtl/rf_writeback_arbiter_pkg.sv
// Shared types and default widths for the register-file writeback arbiter.
// Optional forwarding port is enabled with the RF_WB_FWD_EN macro (see rf_writeback_arbiter.sv).
package rf_wb_pkg;

  localparam int RF_WB_XLEN     = 32;
  localparam int RF_WB_REG_ID_W = 5;
  localparam int RF_WB_NUM_REGS = 32;

  typedef struct packed {
    logic [RF_WB_REG_ID_W-1:0] rd;
    logic [RF_WB_XLEN-1:0]     data;
  } wb_req_t;

  typedef enum logic [1:0] {
    WB_SRC_NONE,
    WB_SRC_ALU,
    WB_SRC_MEM
  } wb_src_e;

endpackage

// File: rtl/rf_writeback_arbiter_if.sv
// Bundle of the ALU/MEM writeback handshakes, register-file write port,
// pending mask and forwarding lookup seen by rf_writeback_arbiter.
interface rf_writeback_arbiter_if
  import rf_wb_pkg::*;
#(
  parameter int XLEN     = RF_WB_XLEN,
  parameter int REG_ID_W = RF_WB_REG_ID_W,
  parameter int NUM_REGS = RF_WB_NUM_REGS
);
  logic                alu_valid;
  logic                alu_ready;
  logic [REG_ID_W-1:0] alu_rd;
  logic [XLEN-1:0]     alu_data;
  logic                mem_valid;
  logic                mem_ready;
  logic [REG_ID_W-1:0] mem_rd;
  logic [XLEN-1:0]     mem_data;
  logic                rf_write_en;
  logic [REG_ID_W-1:0] rf_write_id;
  logic [XLEN-1:0]     rf_write_data;
  logic [NUM_REGS-1:0] pending_mask;
  logic [REG_ID_W-1:0] fwd_id;
  logic                fwd_hit;
  logic [XLEN-1:0]     fwd_data;

  modport master (
    output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data, fwd_id,
    input  alu_ready, mem_ready, rf_write_en, rf_write_id, rf_write_data,
           pending_mask, fwd_hit, fwd_data
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data, fwd_id,
    output alu_ready, mem_ready, rf_write_en, rf_write_id, rf_write_data,
           pending_mask, fwd_hit, fwd_data
  );
endinterface

// File: rtl/rf_writeback_arbiter_wb_skid_buffer.sv
// One-entry valid/ready holding register for a writeback source; requests to
// x0 (or an out-of-range register) are accepted and silently dropped.
module wb_skid_buffer #(
  parameter int XLEN     = 32,
  parameter int REG_ID_W = 5,
  parameter int NUM_REGS = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                src_valid,
  output logic                src_ready,
  input  logic [REG_ID_W-1:0] src_rd,
  input  logic [XLEN-1:0]     src_data,
  input  logic                drain,
  output logic                buf_valid,
  output logic [REG_ID_W-1:0] buf_rd,
  output logic [XLEN-1:0]     buf_data
);
  logic accept;
  logic keep;

  assign src_ready = reset_n && (!buf_valid || drain);
  assign accept    = src_valid && src_ready;
  assign keep      = (src_rd != '0) && (int'(src_rd) < NUM_REGS);

  always_ff @(posedge clk) begin
    if (!reset_n)
      buf_valid <= 1'b0;
    else if (accept)
      buf_valid <= keep;
    else if (drain)
      buf_valid <= 1'b0;
  end

  // Payload is qualified by buf_valid, so it carries no reset.
  always_ff @(posedge clk) begin
    if (accept && keep) begin
      buf_rd   <= src_rd;
      buf_data <= src_data;
    end
  end
endmodule

// File: rtl/rf_writeback_arbiter.sv
// Merges ALU and load writebacks into the single register-file write port with
// MEM priority and ALU anti-starvation. Define RF_WB_FWD_EN to build the forwarding lookup.
module rf_writeback_arbiter
  import rf_wb_pkg::*;
#(
  parameter int XLEN       = RF_WB_XLEN,
  parameter int REG_ID_W   = RF_WB_REG_ID_W,
  parameter int NUM_REGS   = RF_WB_NUM_REGS,
  parameter int STARVE_MAX = 3
) (
  input logic                 clk,
  input logic                 reset_n,
  rf_writeback_arbiter_if.slave wb
);
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  logic                alu_buf_v, mem_buf_v;
  logic [REG_ID_W-1:0] alu_buf_rd, mem_buf_rd;
  logic [XLEN-1:0]     alu_buf_data, mem_buf_data;
  wb_src_e             grant;
  logic [CNT_W-1:0]    starve_cnt, starve_cnt_nxt;

  wb_skid_buffer #(.XLEN(XLEN), .REG_ID_W(REG_ID_W), .NUM_REGS(NUM_REGS)) u_alu_buf (
    .clk(clk), .reset_n(reset_n),
    .src_valid(wb.alu_valid), .src_ready(wb.alu_ready),
    .src_rd(wb.alu_rd), .src_data(wb.alu_data),
    .drain(grant == WB_SRC_ALU),
    .buf_valid(alu_buf_v), .buf_rd(alu_buf_rd), .buf_data(alu_buf_data)
  );

  wb_skid_buffer #(.XLEN(XLEN), .REG_ID_W(REG_ID_W), .NUM_REGS(NUM_REGS)) u_mem_buf (
    .clk(clk), .reset_n(reset_n),
    .src_valid(wb.mem_valid), .src_ready(wb.mem_ready),
    .src_rd(wb.mem_rd), .src_data(wb.mem_data),
    .drain(grant == WB_SRC_MEM),
    .buf_valid(mem_buf_v), .buf_rd(mem_buf_rd), .buf_data(mem_buf_data)
  );

  // No grant while reset is held so nothing in flight reaches the register file.
  always_comb begin
    grant = WB_SRC_NONE;
    if (reset_n) begin
      if (alu_buf_v && mem_buf_v)
        grant = (starve_cnt == STARVE_LIM) ? WB_SRC_ALU : WB_SRC_MEM;
      else if (alu_buf_v)
        grant = WB_SRC_ALU;
      else if (mem_buf_v)
        grant = WB_SRC_MEM;
    end
  end

  always_comb begin
    starve_cnt_nxt = '0;
    if (alu_buf_v && grant != WB_SRC_ALU)
      starve_cnt_nxt = (starve_cnt == STARVE_LIM) ? starve_cnt : starve_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n)
      starve_cnt <= '0;
    else
      starve_cnt <= starve_cnt_nxt;
  end

  always_comb begin
    wb.rf_write_en   = 1'b0;
    wb.rf_write_id   = '0;
    wb.rf_write_data = '0;
    case (grant)
      WB_SRC_ALU: begin
        wb.rf_write_en   = 1'b1;
        wb.rf_write_id   = alu_buf_rd;
        wb.rf_write_data = alu_buf_data;
      end
      WB_SRC_MEM: begin
        wb.rf_write_en   = 1'b1;
        wb.rf_write_id   = mem_buf_rd;
        wb.rf_write_data = mem_buf_data;
      end
      default: ;
    endcase
  end

  // Buffers never hold x0, so bit 0 stays clear.
  always_comb begin
    wb.pending_mask = '0;
    if (alu_buf_v) wb.pending_mask[alu_buf_rd] = 1'b1;
    if (mem_buf_v) wb.pending_mask[mem_buf_rd] = 1'b1;
  end

`ifdef RF_WB_FWD_EN
  // MEM is checked last so it wins when both buffers hold the same register.
  always_comb begin
    wb.fwd_hit  = 1'b0;
    wb.fwd_data = '0;
    if (wb.fwd_id != '0) begin
      if (alu_buf_v && alu_buf_rd == wb.fwd_id) begin
        wb.fwd_hit  = 1'b1;
        wb.fwd_data = alu_buf_data;
      end
      if (mem_buf_v && mem_buf_rd == wb.fwd_id) begin
        wb.fwd_hit  = 1'b1;
        wb.fwd_data = mem_buf_data;
      end
    end
  end
`else
  logic unused_fwd_id;
  assign unused_fwd_id = ^wb.fwd_id;
  assign wb.fwd_hit    = 1'b0;
  assign wb.fwd_data   = '0;
`endif
endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Directed bench for rf_writeback_arbiter: reset, single source, x0 drop,
// contention/anti-starvation, same-rd forwarding, streaming throughput and mid-run reset.
module tb_rf_writeback_arbiter;
  import rf_wb_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  int   n_chk  = 0;
  int   n_fail = 0;

  rf_writeback_arbiter_if wb ();

  rf_writeback_arbiter dut (
    .clk     (clk),
    .reset_n (reset_n),
    .wb      (wb)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_alu(input logic v, input wb_req_t r);
    wb.alu_valid = v;
    wb.alu_rd    = r.rd;
    wb.alu_data  = r.data;
  endtask

  task automatic drive_mem(input logic v, input wb_req_t r);
    wb.mem_valid = v;
    wb.mem_rd    = r.rd;
    wb.mem_data  = r.data;
  endtask

  function automatic wb_req_t alu_item(input int i);
    alu_item.rd   = 5'(16 + (i % 8));
    alu_item.data = 32'hA000_0000 + 32'(i);
  endfunction

  function automatic wb_req_t mem_item(input int i);
    mem_item.rd   = 5'(1 + (i % 15));
    mem_item.data = 32'hB000_0000 + 32'(i);
  endfunction

  initial begin
    int exp_id   [6];
    int present  [6];
    int exp_mrdy [6];
    logic exp_hit;
    logic [31:0] exp_fd;
    int ai, mi, k, ei;
    logic a_hs, m_hs;
    wb_req_t exp_r;

    exp_id   = '{10, 11, 12, 7, 13, 14};
    present  = '{11, 12, 13, 14, 14, 0};
    exp_mrdy = '{1, 1, 1, 0, 1, 1};

    drive_alu(1'b0, '0);
    drive_mem(1'b0, '0);
    wb.fwd_id = '0;
    reset_n   = 1'b0;
    tick();
    tick();
    check_val("rst_we",      64'(wb.rf_write_en), 64'd0);
    check_val("rst_id",      64'(wb.rf_write_id), 64'd0);
    check_val("rst_data",    64'(wb.rf_write_data), 64'd0);
    check_val("rst_pending", 64'(wb.pending_mask), 64'd0);
    check_val("rst_alu_rdy", 64'(wb.alu_ready), 64'd0);
    check_val("rst_mem_rdy", 64'(wb.mem_ready), 64'd0);
    check_val("rst_fwd_hit", 64'(wb.fwd_hit), 64'd0);
    reset_n = 1'b1;
    tick();

    // ALU only
    drive_alu(1'b1, '{rd: 5'd5, data: 32'hDEADBEEF});
    #1;
    check_val("alu_rdy", 64'(wb.alu_ready), 64'd1);
    tick();
    drive_alu(1'b0, '0);
    #1;
    check_val("alu_we",      64'(wb.rf_write_en), 64'd1);
    check_val("alu_id",      64'(wb.rf_write_id), 64'd5);
    check_val("alu_data",    64'(wb.rf_write_data), 64'hDEADBEEF);
    check_val("alu_pending", 64'(wb.pending_mask), 64'h20);
    tick();
    check_val("alu_we_done",   64'(wb.rf_write_en), 64'd0);
    check_val("alu_pend_done", 64'(wb.pending_mask), 64'd0);
    check_val("alu_data_idle", 64'(wb.rf_write_data), 64'd0);

    // x0 drop
    drive_mem(1'b1, '{rd: 5'd0, data: 32'h1234});
    #1;
    check_val("x0_rdy", 64'(wb.mem_ready), 64'd1);
    tick();
    drive_mem(1'b0, '0);
    #1;
    check_val("x0_we",      64'(wb.rf_write_en), 64'd0);
    check_val("x0_pending", 64'(wb.pending_mask), 64'd0);

    // Contention: MEM streams, ALU rd=7 held
    drive_alu(1'b1, '{rd: 5'd7, data: 32'h77});
    drive_mem(1'b1, '{rd: 5'd10, data: 32'h10A});
    for (int c = 0; c < 6; c++) begin
      tick();
      drive_alu(1'b0, '0);
      drive_mem(c < 5, '{rd: 5'(present[c]), data: 32'h100 + 32'(present[c])});
      #1;
      check_val($sformatf("cont_we_%0d", c), 64'(wb.rf_write_en), 64'd1);
      check_val($sformatf("cont_id_%0d", c), 64'(wb.rf_write_id), 64'(exp_id[c]));
      check_val($sformatf("cont_data_%0d", c), 64'(wb.rf_write_data),
                (c == 3) ? 64'h77 : 64'h100 + 64'(exp_id[c]));
      check_val($sformatf("cont_mrdy_%0d", c), 64'(wb.mem_ready), 64'(exp_mrdy[c]));
      if (c == 3)
        check_val("cont_pending", 64'(wb.pending_mask), 64'((32'd1 << 7) | (32'd1 << 13)));
    end
    tick();
    check_val("cont_idle", 64'(wb.rf_write_en), 64'd0);

    // Same rd in both buffers, forwarding lookup
    drive_alu(1'b1, '{rd: 5'd9, data: 32'h55});
    drive_mem(1'b1, '{rd: 5'd9, data: 32'h66});
    tick();
    drive_alu(1'b0, '0);
    drive_mem(1'b0, '0);
    wb.fwd_id = 5'd9;
    #1;
`ifdef RF_WB_FWD_EN
    exp_hit = 1'b1;
    exp_fd  = 32'h66;
`else
    exp_hit = 1'b0;
    exp_fd  = 32'h0;
`endif
    check_val("same_pending", 64'(wb.pending_mask), 64'h200);
    check_val("same_id0",     64'(wb.rf_write_id), 64'd9);
    check_val("same_data0",   64'(wb.rf_write_data), 64'h66);
    check_val("fwd_hit9",     64'(wb.fwd_hit), 64'(exp_hit));
    check_val("fwd_data9",    64'(wb.fwd_data), 64'(exp_fd));
    wb.fwd_id = 5'd0;
    #1;
    check_val("fwd_hit0", 64'(wb.fwd_hit), 64'd0);
    wb.fwd_id = 5'd9;
    tick();
`ifdef RF_WB_FWD_EN
    exp_fd = 32'h55;
`endif
    check_val("same_data1",    64'(wb.rf_write_data), 64'h55);
    check_val("same_pending1", 64'(wb.pending_mask), 64'h200);
    check_val("fwd_data_alu",  64'(wb.fwd_data), 64'(exp_fd));
    tick();
    wb.fwd_id = 5'd0;
    check_val("same_idle_we",   64'(wb.rf_write_en), 64'd0);
    check_val("same_idle_pend", 64'(wb.pending_mask), 64'd0);

    // Throughput: both sources always valid; expected order M,M,M,A repeating
    ai = 0;
    mi = 0;
    drive_alu(1'b1, alu_item(0));
    drive_mem(1'b1, mem_item(0));
    tick();
    ai = 1;
    mi = 1;
    drive_alu(1'b1, alu_item(ai));
    drive_mem(1'b1, mem_item(mi));
    for (k = 0; k < 20; k++) begin
      #1;
      ei    = k - (k + 1) / 4;
      exp_r = ((k % 4) == 3) ? alu_item(k / 4) : mem_item(ei);
      check_val($sformatf("thr_we_%0d", k),   64'(wb.rf_write_en), 64'd1);
      check_val($sformatf("thr_id_%0d", k),   64'(wb.rf_write_id), 64'(exp_r.rd));
      check_val($sformatf("thr_data_%0d", k), 64'(wb.rf_write_data), 64'(exp_r.data));
      a_hs = wb.alu_ready;
      m_hs = wb.mem_ready;
      tick();
      if (a_hs) ai++;
      if (m_hs) mi++;
      drive_alu(1'b1, alu_item(ai));
      drive_mem(1'b1, mem_item(mi));
    end
    check_val("thr_alu_count", 64'(ai), 64'd6);
    check_val("thr_mem_count", 64'(mi), 64'd16);

    // Reset with both buffers full
    #1;
    check_val("mid_full_pend", 64'(wb.pending_mask != '0), 64'd1);
    reset_n = 1'b0;
    drive_alu(1'b0, '0);
    drive_mem(1'b0, '0);
    #1;
    check_val("mid_rst_we",      64'(wb.rf_write_en), 64'd0);
    check_val("mid_rst_alu_rdy", 64'(wb.alu_ready), 64'd0);
    check_val("mid_rst_mem_rdy", 64'(wb.mem_ready), 64'd0);
    tick();
    check_val("mid_rst_pend", 64'(wb.pending_mask), 64'd0);
    reset_n = 1'b1;
    tick();
    check_val("post_rst_we",   64'(wb.rf_write_en), 64'd0);
    check_val("post_rst_pend", 64'(wb.pending_mask), 64'd0);
    check_val("post_rst_rdy",  64'(wb.alu_ready), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
